// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store stage: access-size codes, FSM states
// and the byte-enable helper used by the lane logic.
package load_store_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // Size code 2'b11 is not a legal encoding; it is handled as a word.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << offset;
         SZ_HALF: be = 4'b0011 << {offset[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign or zero extension.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [31:0] byte_lane;
   logic [31:0] half_lane;

   // Shift the addressed lane down to bit 0; half offsets ignore bit 0 (force-align).
   assign byte_lane = rdata >> {offset, 3'b000};
   assign half_lane = rdata >> {offset[1], 4'b0000};
   assign be        = byte_en(funct3[1:0], offset);

   always_comb begin
      wdata_rep = wdata;
      load_data = rdata;
      case (funct3[1:0])
         SZ_BYTE: begin
            wdata_rep = {4{wdata[7:0]}};
            load_data = funct3[2] ? {24'd0, byte_lane[7:0]}
                                  : {{24{byte_lane[7]}}, byte_lane[7:0]};
         end
         SZ_HALF: begin
            wdata_rep = {2{wdata[15:0]}};
            load_data = funct3[2] ? {16'd0, half_lane[15:0]}
                                  : {{16{half_lane[15]}}, half_lane[15:0]};
         end
         default: begin
            wdata_rep = wdata;
            load_data = rdata;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: pass-through for ALU results, req/ack bus access for
// loads and stores with a bounded wait. Optional LSU_MISALIGN_TRAP_EN traps
// misaligned half/word accesses instead of force-aligning them.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_is_load,
   input  logic                  in_is_store,
   input  logic [2:0]            in_funct3,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [31:0]           in_wdata,
   input  logic [4:0]            in_rd,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_rdata,
   output logic                  out_valid,
   output logic [4:0]            out_rd,
   output logic [31:0]           out_data,
   output logic                  out_we,
   output logic                  out_err
);

   // Handshake: execute transfers an instruction on a cycle where in_valid && in_ready;
   // the bus request holds all attributes until mem_ack or timeout.

   lsu_state_e            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  is_load_q, is_load_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [4:0]            rd_q, rd_d;
   logic                  out_valid_d, out_we_d, out_err_d;
   logic [4:0]            out_rd_d;
   logic [31:0]           out_data_d;
   logic [31:0]           load_data;
   logic [7:0]            cnt_inc;
   logic                  accept;

   lsu_align u_align (
      .funct3    (funct3_q),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (mem_rdata),
      .be        (mem_be),
      .wdata_rep (mem_wdata),
      .load_data (load_data)
   );

   assign in_ready = (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign mem_req  = (state_q == REQ);
   assign mem_we   = mem_req && !is_load_q;
   assign mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign cnt_inc  = cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_load_d   = is_load_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      out_valid_d = 1'b0;
      out_we_d    = 1'b0;
      out_err_d   = 1'b0;
      out_rd_d    = out_rd;
      out_data_d  = out_data;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_is_load || in_is_store) begin
                  is_load_d = in_is_load;
                  funct3_d  = in_funct3;
                  addr_d    = in_addr;
                  wdata_d   = in_wdata;
                  rd_d      = in_is_load ? in_rd : 5'd0;
                  cnt_d     = 8'd0;
                  state_d   = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                  if ((in_funct3[1:0] == SZ_HALF && in_addr[0]) ||
                      (in_funct3[1] && in_addr[1:0] != 2'b00)) begin
                     state_d     = DONE;
                     out_valid_d = 1'b1;
                     out_rd_d    = in_is_load ? in_rd : 5'd0;
                     out_data_d  = 32'd0;
                     out_err_d   = 1'b1;
                  end
`endif
               end else begin
                  out_valid_d = 1'b1;
                  out_rd_d    = in_rd;
                  out_data_d  = 32'(in_addr);
                  out_we_d    = (in_rd != 5'd0);
               end
            end
         end
         REQ: begin
            // Ack wins over a timeout landing on the same cycle.
            if (mem_ack) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_rd_d    = rd_q;
               out_data_d  = is_load_q ? load_data : 32'd0;
               out_we_d    = is_load_q && (rd_q != 5'd0);
            end else if (cnt_inc == 8'(MAX_WAIT)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_rd_d    = rd_q;
               out_data_d  = 32'd0;
               out_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         is_load_q <= 1'b0;
         funct3_q  <= 3'd0;
         addr_q    <= '0;
         wdata_q   <= 32'd0;
         rd_q      <= 5'd0;
         out_valid <= 1'b0;
         out_rd    <= 5'd0;
         out_data  <= 32'd0;
         out_we    <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_load_q <= is_load_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         out_valid <= out_valid_d;
         out_rd    <= out_rd_d;
         out_data  <= out_data_d;
         out_we    <= out_we_d;
         out_err   <= out_err_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: pass-through, loads, stores, timeout,
// misaligned access and reset during an outstanding request.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_is_load, in_is_store;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        out_valid, out_we, out_err;
   logic [4:0]  out_rd;
   logic [31:0] out_data;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   load_store_unit #(.ADDR_WIDTH(32), .MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
      .in_is_store(in_is_store), .in_funct3(in_funct3), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
      .out_we(out_we), .out_err(out_err)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive_idle();
      in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 3'b000;
      in_addr = 0; in_wdata = 0; in_rd = 0; mem_ack = 0; mem_rdata = 0;
   endtask

   task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      in_valid = 1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
      in_addr = addr; in_wdata = wd; in_rd = rd;
   endtask

   initial begin
      int n;
      int seen;
      drive_idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_err", out_err, 0);

      // pass-through, three back-to-back
      drive_op(0, 0, 3'b000, 32'h1234, 0, 5'd5);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'h1234);
         tick();
         chk("pt_valid", out_valid, 1);
         chk("pt_data", out_data, exp_q.pop_front());
         chk("pt_rd", out_rd, 5);
         chk("pt_we", out_we, 1);
         chk("pt_ready", in_ready, 1);
      end
      drive_op(0, 0, 3'b000, 32'h1234, 0, 5'd0);
      tick();
      chk("pt_rd0_valid", out_valid, 1);
      chk("pt_rd0_we", out_we, 0);
      drive_idle();
      tick();
      chk("pt_idle_valid", out_valid, 0);

      // ack while idle is ignored
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      chk("idle_ack_valid", out_valid, 0);
      chk("idle_ack_ready", in_ready, 1);
      drive_idle();

      // signed byte load, ack after 2 cycles
      drive_op(1, 0, 3'b000, 32'h103, 0, 5'd7);
      tick();
      drive_idle();
      chk("lb_req", mem_req, 1);
      chk("lb_addr", mem_addr, 32'h100);
      chk("lb_be", mem_be, 4'b1000);
      chk("lb_we", mem_we, 0);
      chk("lb_ready", in_ready, 0);
      chk("lb_early_valid", out_valid, 0);
      tick();
      chk("lb_req2", mem_req, 1);
      chk("lb_ready2", in_ready, 0);
      mem_ack = 1; mem_rdata = 32'h80FF_1234;
      tick();
      mem_ack = 0;
      chk("lb_valid", out_valid, 1);
      chk("lb_data", out_data, 32'hFFFF_FF80);
      chk("lb_we_out", out_we, 1);
      chk("lb_rd", out_rd, 7);
      chk("lb_err", out_err, 0);
      chk("lb_done_ready", in_ready, 0);
      tick();
      chk("lb_after_valid", out_valid, 0);
      chk("lb_after_ready", in_ready, 1);

      // unsigned byte load, ack in first REQ cycle: result 2 cycles after accept
      drive_op(1, 0, 3'b100, 32'h103, 0, 5'd8);
      tick();
      drive_idle();
      mem_ack = 1; mem_rdata = 32'h80FF_1234;
      tick();
      mem_ack = 0;
      chk("lbu_valid", out_valid, 1);
      chk("lbu_data", out_data, 32'h0000_0080);
      tick();

      // half store
      drive_op(0, 1, 3'b001, 32'h22, 32'hDEAD_BEEF, 5'd9);
      tick();
      drive_idle();
      chk("sh_req", mem_req, 1);
      chk("sh_we", mem_we, 1);
      chk("sh_addr", mem_addr, 32'h20);
      chk("sh_be", mem_be, 4'b1100);
      chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      mem_ack = 1;
      tick();
      mem_ack = 0;
      chk("sh_valid", out_valid, 1);
      chk("sh_out_we", out_we, 0);
      chk("sh_err", out_err, 0);
      tick();

      // timeout: never ack
      drive_op(1, 0, 3'b010, 32'h40, 0, 5'd3);
      tick();
      drive_idle();
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", n, 15);
      chk("to_valid", out_valid, 1);
      chk("to_err", out_err, 1);
      chk("to_we", out_we, 0);
      tick();

      // ack on the 15th REQ cycle counts as success
      drive_op(1, 0, 3'b010, 32'h40, 0, 5'd3);
      tick();
      drive_idle();
      for (int i = 0; i < 14; i++) tick();
      chk("ack15_req", mem_req, 1);
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ack = 0;
      chk("ack15_valid", out_valid, 1);
      chk("ack15_err", out_err, 0);
      chk("ack15_data", out_data, 32'h1234_5678);
      chk("ack15_we", out_we, 1);
      tick();

      // misaligned word load
      drive_op(1, 0, 3'b010, 32'h102, 0, 5'd4);
      tick();
      drive_idle();
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_req", mem_req, 0);
      chk("mis_valid", out_valid, 1);
      chk("mis_err", out_err, 1);
      chk("mis_we", out_we, 0);
`else
      chk("mis_req", mem_req, 1);
      chk("mis_addr", mem_addr, 32'h100);
      chk("mis_be", mem_be, 4'b1111);
      mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 0;
      chk("mis_valid", out_valid, 1);
      chk("mis_data", out_data, 32'hCAFE_F00D);
      chk("mis_err", out_err, 0);
`endif
      tick();

      // reset while a request is outstanding
      drive_op(1, 0, 3'b010, 32'h10, 0, 5'd6);
      tick();
      drive_idle();
      chk("rr_req", mem_req, 1);
      reset = 1;
      tick();
      reset = 0;
      chk("rr_req_drop", mem_req, 0);
      chk("rr_ready", in_ready, 1);
      chk("rr_valid", out_valid, 0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = 1;
         tick();
         if (out_valid) seen++;
      end
      mem_ack = 0;
      chk("rr_no_result", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
